mhp_link_scheduler: RTL and testbench

- Parametrised successor to the MHP task controller: owns link bring-up, keepalive and arbitration of N_TASK client send requests onto one MHP protocol engine.
- Drives the engine's send/done control handshake with per-transaction timeout and bounded retry, and reports link state.
- Sits between application task logic and the mhp engine.
- Carries control only; the Ethernet data path stays inside mhp.

---
 rtl/mhp_pkg.sv | 32 +++
 rtl/mhp_rr_arbiter.sv | 45 ++++
 rtl/mhp_link_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_mhp_link_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mhp_pkg.sv
// Shared definitions for the MHP control blocks: scheduler states, reserved
// transaction ids and the default timing constants used alongside the mhp engine.
package mhp_pkg;

    localparam int DEF_TIMEOUT_CYC   = 1024;
    localparam int DEF_MAX_RETRY     = 3;
    localparam int DEF_KEEPALIVE_CYC = 65536;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HELLO  = 3'd1,
        ST_LINKED = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5
    } mhp_state_t;

    // Ids above the task range are reserved for link maintenance traffic.
    function automatic int id_keep(input int n_task);
        return n_task;
    endfunction

    function automatic int id_hello(input int n_task);
        return n_task + 1;
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int width_of(input int max_val);
        return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mhp_rr_arbiter.sv
// Round-robin picker over the task request lines; the pointer only moves
// when the scheduler actually takes the offered grant.
module mhp_rr_arbiter
    import mhp_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [IW-1:0] grant,
    output logic          grant_valid,
    output logic [IW-1:0] ptr
);

    logic [IW-1:0] ptr_r;

    // Lowest requester overall covers the wrap case; lowest at/above the pointer overrides it.
    always_comb begin
        grant = {IW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            grant = req[i] ? IW'(i) : grant;
        end
        for (int i = N - 1; i >= 0; i--) begin
            grant = (req[i] && (IW'(i) >= ptr_r)) ? IW'(i) : grant;
        end
    end

    assign grant_valid = |req;
    assign ptr         = ptr_r;

    // Pointer lands just past the granted index, wrapping at N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {IW{1'b0}};
        end else if (advance && grant_valid) begin
            ptr_r <= (grant == IW'(N - 1)) ? {IW{1'b0}} : grant + IW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mhp_link_scheduler.sv
// Link bring-up, keepalive and round-robin task arbitration in front of one
// mhp engine, driving its send/done handshake with timeout and bounded retry.
module mhp_link_scheduler
    import mhp_pkg::*;
#(
    parameter int N_TASK        = 4,
    parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int KEEPALIVE_CYC = DEF_KEEPALIVE_CYC,
    parameter int ID_W          = $clog2(N_TASK + 2)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_link_drop,
    input  logic [N_TASK-1:0] i_task_req,
    output logic [N_TASK-1:0] o_task_ack,
    output logic [N_TASK-1:0] o_task_err,
    output logic              o_send,
    output logic [ID_W-1:0]   o_send_id,
    input  logic              i_done,
    output logic              o_link,
    output logic              o_link_lost,
    output logic              o_busy
);

    localparam int TMR_W = width_of(TIMEOUT_CYC);
    localparam int RTY_W = width_of(MAX_RETRY);
    localparam int KA_W  = width_of(KEEPALIVE_CYC);
    localparam logic [ID_W-1:0] ID_KEEP_L  = ID_W'(id_keep(N_TASK));
    localparam logic [ID_W-1:0] ID_HELLO_L = ID_W'(id_hello(N_TASK));

    mhp_state_t        state_r;
    logic [ID_W-1:0]   id_r;
    logic [TMR_W-1:0]  timer_r;
    logic [RTY_W-1:0]  retry_r;
    logic [KA_W-1:0]   ka_r;
    logic              fail_r;
    logic              send_r;
    logic              link_r;
    logic              lost_r;
    logic              busy_r;
    logic [N_TASK-1:0] ack_r;
    logic [N_TASK-1:0] err_r;

    logic [ID_W-1:0]   grant_s;
    logic              grant_valid_s;
    logic              link_drop_s;
    logic              take_task_s;
    logic              id_is_task_s;
    logic [N_TASK-1:0] task_onehot_s;
    logic [KA_W-1:0]   ka_inc_s;

    // A drop only matters once the link is up; during hello it is ignored.
    assign link_drop_s   = i_link_drop && link_r;
    assign take_task_s   = (state_r == ST_LINKED) && !link_drop_s && i_enable && grant_valid_s;
    assign id_is_task_s  = (id_r < ID_KEEP_L);
    assign task_onehot_s = N_TASK'(1'b1) << id_r;
    assign ka_inc_s      = (ka_r == KA_W'(KEEPALIVE_CYC)) ? ka_r : ka_r + KA_W'(1);

    mhp_rr_arbiter #(
        .N  (N_TASK),
        .IW (ID_W)
    ) u_arb (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .req         (i_task_req),
        .advance     (take_task_s),
        .grant       (grant_s),
        .grant_valid (grant_valid_s),
        .ptr         ()
    );

    // Scheduler FSM; every output is a register so pulses line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            id_r    <= {ID_W{1'b0}};
            timer_r <= {TMR_W{1'b0}};
            retry_r <= {RTY_W{1'b0}};
            ka_r    <= {KA_W{1'b0}};
            fail_r  <= 1'b0;
            send_r  <= 1'b0;
            link_r  <= 1'b0;
            lost_r  <= 1'b0;
            busy_r  <= 1'b0;
            ack_r   <= {N_TASK{1'b0}};
            err_r   <= {N_TASK{1'b0}};
        end else begin
            send_r <= 1'b0;
            lost_r <= 1'b0;
            ack_r  <= {N_TASK{1'b0}};
            err_r  <= {N_TASK{1'b0}};
            if (link_drop_s) begin
                // Outstanding task stays unanswered; its held request is served after relink.
                state_r <= ST_IDLE;
                link_r  <= 1'b0;
                lost_r  <= 1'b1;
                busy_r  <= 1'b0;
                retry_r <= {RTY_W{1'b0}};
                fail_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        retry_r <= {RTY_W{1'b0}};
                        if (i_enable) begin
                            id_r    <= ID_HELLO_L;
                            state_r <= ST_ISSUE;
                            send_r  <= 1'b1;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_LINKED: begin
                        if (!i_enable) begin
                            state_r <= ST_IDLE;
                            link_r  <= 1'b0;
                            lost_r  <= 1'b1;
                        end else if (grant_valid_s) begin
                            id_r    <= grant_s;
                            state_r <= ST_ISSUE;
                            send_r  <= 1'b1;
                            busy_r  <= 1'b1;
                        end else if (ka_inc_s == KA_W'(KEEPALIVE_CYC)) begin
                            id_r    <= ID_KEEP_L;
                            state_r <= ST_ISSUE;
                            send_r  <= 1'b1;
                            busy_r  <= 1'b1;
                        end else begin
                            ka_r <= ka_inc_s;
                        end
                    end
                    ST_ISSUE: begin
                        timer_r <= TMR_W'(1);
                        state_r <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        // timer_r counts WAIT cycles including this one, so done on the last one still wins.
                        if (i_done) begin
                            state_r <= ST_DONE;
                            fail_r  <= 1'b0;
                            busy_r  <= 1'b0;
                            ack_r   <= id_is_task_s ? task_onehot_s : {N_TASK{1'b0}};
                        end else if (timer_r == TMR_W'(TIMEOUT_CYC)) begin
                            if (retry_r < RTY_W'(MAX_RETRY)) begin
                                retry_r <= retry_r + RTY_W'(1);
                                state_r <= ST_ISSUE;
                                send_r  <= 1'b1;
                            end else begin
                                state_r <= ST_DONE;
                                fail_r  <= 1'b1;
                                busy_r  <= 1'b0;
                                err_r   <= id_is_task_s ? task_onehot_s : {N_TASK{1'b0}};
                            end
                        end else begin
                            timer_r <= timer_r + TMR_W'(1);
                        end
                    end
                    ST_DONE: begin
                        retry_r <= {RTY_W{1'b0}};
                        ka_r    <= {KA_W{1'b0}};
                        if (!fail_r) begin
                            state_r <= ST_LINKED;
                            link_r  <= (id_r == ID_HELLO_L) ? 1'b1 : link_r;
                        end else if (id_r == ID_HELLO_L) begin
                            state_r <= ST_IDLE;
                        end else if (id_r == ID_KEEP_L) begin
                            state_r <= ST_IDLE;
                            link_r  <= 1'b0;
                            lost_r  <= 1'b1;
                        end else begin
                            state_r <= ST_LINKED;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        link_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_send      = send_r;
    assign o_send_id   = id_r;
    assign o_link      = link_r;
    assign o_link_lost = lost_r;
    assign o_busy      = busy_r;
    assign o_task_ack  = ack_r;
    assign o_task_err  = err_r;

endmodule

// File: tb/tb_mhp_link_scheduler.sv
// Directed bench for mhp_link_scheduler with N_TASK=4, TIMEOUT_CYC=16,
// MAX_RETRY=2, KEEPALIVE_CYC=64; expected ids and cycle gaps are hand-derived.
module tb_mhp_link_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       link_drop = 1'b0;
    logic       done = 1'b0;
    logic [3:0] task_req = 4'b0000;
    logic [3:0] task_ack;
    logic [3:0] task_err;
    logic       send;
    logic [2:0] send_id;
    logic       link;
    logic       link_lost;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_send = 0;
    int ok;
    int base;
    int c_prev;
    int c_now;
    int rr_ids [6] = '{0, 1, 3, 0, 1, 3};

    mhp_link_scheduler #(
        .N_TASK        (4),
        .TIMEOUT_CYC   (16),
        .MAX_RETRY     (2),
        .KEEPALIVE_CYC (64)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_link_drop (link_drop),
        .i_task_req  (task_req),
        .o_task_ack  (task_ack),
        .o_task_err  (task_err),
        .o_send      (send),
        .o_send_id   (send_id),
        .i_done      (done),
        .o_link      (link),
        .o_link_lost (link_lost),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (send) n_send++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for the next send pulse and check its id.
    task automatic wait_send(input string tag, input int exp_id, output int at);
        int seen;
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            tick(1);
            if (send) seen = 1;
        end
        check({tag, "_seen"}, seen, 1);
        check({tag, "_id"}, int'(send_id), exp_id);
        at = cyc;
    endtask

    // Assert done so it is sampled on the k-th edge after the send cycle.
    task automatic answer(input int k);
        tick(k - 1);
        done = 1'b1;
        tick(1);
        done = 1'b0;
    endtask

    function automatic int all_outs();
        return int'({send, send_id, link, link_lost, busy, task_ack, task_err});
    endfunction

    initial begin
        tick(3);
        check("reset_outs", all_outs(), 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        wait_send("hello", 5, c_now);
        check("hello_busy", int'(busy), 1);
        answer(3);
        check("hello_link_early", int'(link), 0);
        tick(1);
        check("hello_link", int'(link), 1);

        task_req = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            wait_send("rr", rr_ids[i], c_now);
            answer(2);
            check("rr_ack", int'(task_ack), 1 << rr_ids[i]);
        end

        task_req = 4'b0100;
        base = n_send;
        wait_send("retry0", 2, c_prev);
        for (int i = 1; i < 3; i++) begin
            wait_send("retry", 2, c_now);
            check("retry_gap", c_now - c_prev, 17);
            c_prev = c_now;
        end
        ok = 0;
        for (int i = 0; i < 40 && ok == 0; i++) begin
            tick(1);
            if (task_err != 4'b0000) ok = 1;
        end
        check("retry_err", int'(task_err), 4);
        check("retry_sends", n_send - base, 3);
        check("retry_link", int'(link), 1);

        task_req = 4'b0000;
        tick(1);
        base = cyc;
        wait_send("keep0", 4, c_prev);
        check("keep_gap", c_prev - base, 64);
        for (int i = 1; i < 3; i++) begin
            wait_send("keep", 4, c_now);
            check("keep_retry_gap", c_now - c_prev, 17);
            c_prev = c_now;
        end
        tick(17);
        check("keep_link_held", int'(link), 1);
        tick(1);
        check("keep_lost", int'(link_lost), 1);
        check("keep_link_down", int'(link), 0);
        wait_send("rehello", 5, c_now);
        check("rehello_gap", c_now - c_prev, 19);
        answer(2);
        tick(1);
        check("relink", int'(link), 1);

        task_req = 4'b0010;
        wait_send("t1", 1, c_now);
        tick(2);
        link_drop = 1'b1;
        tick(1);
        link_drop = 1'b0;
        check("drop_link", int'(link), 0);
        check("drop_lost", int'(link_lost), 1);
        check("drop_ackerr", int'({task_ack, task_err}), 0);
        wait_send("drop_hello", 5, c_now);
        tick(1);
        link_drop = 1'b1;
        tick(1);
        link_drop = 1'b0;
        check("hello_drop_ignored", int'(link_lost), 0);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        tick(1);
        check("drop_relink", int'(link), 1);
        wait_send("t1_resend", 1, c_now);
        answer(2);
        check("t1_ack", int'(task_ack), 2);

        task_req = 4'b0001;
        wait_send("t0", 0, c_now);
        answer(17);
        check("edge_ack", int'(task_ack), 1);
        check("edge_no_retry", int'(send), 0);

        task_req = 4'b0100;
        wait_send("t2", 2, c_now);
        tick(3);
        rst_n = 1'b0;
        #1;
        check("async_reset", all_outs(), 0);
        #20;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
